// File: rtl/key_event_n.sv
// key_event_n: debounced multi-key press/release/long-press/auto-repeat event generator
//   key_clk      : sole clock, rising edge
//   key_rst      : asynchronous active-high reset
//   key_in       : raw active-low key pins (asynchronous)
//   repeat_en    : enable auto-repeat after a long press
//   key_level    : debounced per-key state, 1 = pressed
//   key_press    : one-cycle pulse on confirmed press
//   key_release  : one-cycle pulse on confirmed release
//   key_long     : one-cycle pulse when the hold reaches LONG_TICKS
//   key_repeat   : one-cycle pulse on every auto-repeat
//   key_any      : OR of key_level
module key_event_n #(
  parameter int KEY_NUM      = 4,
  parameter int TICK_MAX     = 500_000,
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic               key_clk,
  input  logic               key_rst,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               repeat_en,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat,
  output logic               key_any
);
  localparam int TW   = $clog2(TICK_MAX);
  localparam int HMAX = LONG_TICKS + REPEAT_TICKS;
  localparam int HW   = $clog2(HMAX + 1);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
  logic [KEY_NUM-1:0] sync1, sync2;
  logic [TW-1:0] tick_cnt;
  logic tick;
  assign tick = tick_cnt == TW'(TICK_MAX - 1);
  assign key_any = |key_level;
  always_ff @(posedge key_clk or posedge key_rst) begin
    if (key_rst) begin
      tick_cnt <= '0;
      sync1    <= '1;
      sync2    <= '1;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sync1    <= key_in;
      sync2    <= sync1;
    end
  end
  for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
    state_t state, state_nxt;
    logic [HW-1:0] hold, hold_nxt, inc;
    logic low, lvl, lvl_nxt, press, press_nxt, rel, rel_nxt, lng, lng_nxt, rep, rep_nxt;
    assign low = !sync2[k];
    // saturating increment: a saturated counter never wraps back to zero
    assign inc = (hold == HW'(HMAX)) ? hold : hold + 1'b1;
    always_comb begin
      state_nxt = state;
      hold_nxt  = hold;
      lvl_nxt   = lvl;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
      lng_nxt   = 1'b0;
      rep_nxt   = 1'b0;
      if (tick) begin
        case (state)
          IDLE:      state_nxt = low ? PRESS_CHK : IDLE;
          PRESS_CHK: begin
            state_nxt = low ? HELD : IDLE;
            lvl_nxt   = low;
            press_nxt = low;
            hold_nxt  = low ? '0 : hold;
          end
          HELD: begin
            state_nxt = low ? HELD : REL_CHK;
            if (low) begin
              // the repeat reload to LONG_TICKS goes around this path, so long fires only once
              lng_nxt  = inc == HW'(LONG_TICKS);
              rep_nxt  = repeat_en && inc == HW'(HMAX);
              hold_nxt = rep_nxt ? HW'(LONG_TICKS) : inc;
            end
          end
          default: begin
            state_nxt = low ? HELD : IDLE;
            lvl_nxt   = low;
            rel_nxt   = !low;
          end
        endcase
      end
    end
    always_ff @(posedge key_clk or posedge key_rst) begin
      if (key_rst) begin
        state <= IDLE;
        hold  <= '0;
        lvl   <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        lng   <= 1'b0;
        rep   <= 1'b0;
      end else begin
        state <= state_nxt;
        hold  <= hold_nxt;
        lvl   <= lvl_nxt;
        press <= press_nxt;
        rel   <= rel_nxt;
        lng   <= lng_nxt;
        rep   <= rep_nxt;
      end
    end
    assign key_level[k]   = lvl;
    assign key_press[k]   = press;
    assign key_release[k] = rel;
    assign key_long[k]    = lng;
    assign key_repeat[k]  = rep;
  end
endmodule

// File: tb/tb_key_event_n.sv
// tb_key_event_n: scoreboard bench for key_event_n with directed key patterns
module tb_key_event_n;
  logic clk = 1'b0, rst = 1'b1, repeat_en = 1'b0;
  logic [3:0] key_in = 4'b1111;
  logic [3:0] key_level, key_press, key_release, key_long, key_repeat;
  logic key_any;
  typedef struct {logic [3:0] p, r, l, q, v; int t;} ev_t;
  ev_t sb[$];
  ev_t e;
  int n_cmp = 0, n_err = 0, cyc = 0, b = 0;
  key_event_n #(.KEY_NUM(4), .TICK_MAX(4), .LONG_TICKS(5), .REPEAT_TICKS(2)) dut (
    .key_clk(clk), .key_rst(rst), .key_in(key_in), .repeat_en(repeat_en),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .key_repeat(key_repeat), .key_any(key_any));
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task tk(input int n);
    repeat (4 * n) @(posedge clk);
    #1;
  endtask
  task push(input logic [3:0] p, r, l, q, v, input int k);
    sb.push_back('{p, r, l, q, v, b + 4 * k});
  endtask
  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && |{key_press, key_release, key_long, key_repeat}) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got p=%b r=%b l=%b q=%b at cyc %0d, required none",
                     key_press, key_release, key_long, key_repeat, cyc);
          end else begin
            e = sb.pop_front();
            if ({key_press, key_release, key_long, key_repeat, key_level} !== {e.p, e.r, e.l, e.q, e.v} || cyc != e.t) begin
              n_err++;
              $display("FAIL event: got p=%b r=%b l=%b q=%b v=%b cyc=%0d, required p=%b r=%b l=%b q=%b v=%b cyc=%0d",
                       key_press, key_release, key_long, key_repeat, key_level, cyc, e.p, e.r, e.l, e.q, e.v, e.t);
            end
          end
        end
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {11'd0, key_level, key_press, key_release, key_long, key_repeat, key_any}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tk(1);
    chk("idle_level", {28'd0, key_level}, 32'd0);
    // short press and release of key 0
    b = cyc;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2);
    push(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5);
    key_in = 4'b1110; tk(3);
    key_in = 4'b1111; tk(3);
    chk("t1_level", {28'd0, key_level}, 32'd0);
    // one-tick glitch on key 1 is rejected
    key_in = 4'b1101; tk(1);
    chk("glitch_level", {28'd0, key_level}, 32'd0);
    key_in = 4'b1111; tk(3);
    chk("glitch_level_after", {31'd0, key_any}, 32'd0);
    // long hold of key 2 with auto-repeat
    repeat_en = 1'b1;
    b = cyc;
    push(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2);
    push(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 7);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 9);
    push(4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 11);
    push(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 14);
    key_in = 4'b1011; tk(12);
    key_in = 4'b1111; tk(3);
    // same hold without repeat: counter saturates, no repeat, no second long
    repeat_en = 1'b0;
    b = cyc;
    push(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 2);
    push(4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 7);
    push(4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 14);
    key_in = 4'b1011; tk(12);
    key_in = 4'b1111; tk(3);
    // keys 0 and 3 pressed together, released apart
    b = cyc;
    push(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 2);
    push(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 5);
    push(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 8);
    key_in = 4'b0110; tk(3);
    chk("dual_any", {31'd0, key_any}, 32'd1);
    key_in = 4'b0111; tk(3);
    chk("dual_level_mid", {28'd0, key_level}, 32'h8);
    chk("dual_any_mid", {31'd0, key_any}, 32'd1);
    key_in = 4'b1111; tk(3);
    chk("dual_any_end", {31'd0, key_any}, 32'd0);
    // reset while key 0 is held, then re-detection
    b = cyc;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2);
    key_in = 4'b1110; tk(4);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {11'd0, key_level, key_press, key_release, key_long, key_repeat, key_any}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b = cyc;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2);
    tk(2);
    chk("redetect_level", {28'd0, key_level}, 32'h1);
    b = cyc;
    push(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    key_in = 4'b1111; tk(3);
    // held key with a one-tick release glitch keeps its hold count
    b = cyc;
    push(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2);
    push(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 9);
    push(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 11);
    key_in = 4'b1110; tk(3);
    key_in = 4'b1111; tk(1);
    chk("relchk_level", {28'd0, key_level}, 32'h1);
    key_in = 4'b1110; tk(5);
    key_in = 4'b1111; tk(3);
    tk(1);
    chk("pending_events", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/key_event_n.md
KEY_EVENT_N -- requirements
Module: key_event_n

Interface
REQ-001 SHALL have parameter KEY_NUM, default 4: number of independent active-low key inputs, range 1..16.
REQ-002 SHALL have parameter TICK_MAX, default 500_000: clocks per sample tick (10 ms at 50 MHz), minimum 2.
REQ-003 SHALL have parameter LONG_TICKS, default 100: held ticks before a long-press event, minimum 2.
REQ-004 SHALL have parameter REPEAT_TICKS, default 20: ticks between auto-repeat events after a long press, minimum 1.
REQ-005 key_clk  input  1  sole clock; all logic on the rising edge.
REQ-006 key_rst  input  1  asynchronous, active-high reset.
REQ-007 key_in  input  KEY_NUM  raw key pins, 0 = pressed, asynchronous to key_clk.
REQ-008 repeat_en  input  1  1 = auto-repeat enabled, sampled on each tick.
REQ-009 key_level  output  KEY_NUM  debounced state per key, 1 = pressed.
REQ-010 key_press  output  KEY_NUM  one-clock pulse per key on confirmed press.
REQ-011 key_release  output  KEY_NUM  one-clock pulse per key on confirmed release.
REQ-012 key_long  output  KEY_NUM  one-clock pulse per key when the hold reaches LONG_TICKS.
REQ-013 key_repeat  output  KEY_NUM  one-clock pulse per key on each auto-repeat.
REQ-014 key_any  output  1  OR of key_level.

Function
REQ-015 SHALL pass key_in through a 2-flop synchroniser per bit; all decisions SHALL use the synchronised value.
REQ-016 SHALL run one shared tick counter 0..TICK_MAX-1 that wraps; tick is true in the cycle the counter equals TICK_MAX-1.
REQ-017 SHALL give each key an independent FSM that advances only on tick: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-018 IDLE: sample low -> PRESS_CHK; otherwise stay.
REQ-019 PRESS_CHK: sample low -> HELD, key_level=1, pulse key_press, clear hold counter; sample high -> IDLE with no event (glitch rejected).
REQ-020 HELD: sample high -> REL_CHK; sample low -> hold counter +1, saturating at LONG_TICKS+REPEAT_TICKS.
REQ-021 REL_CHK: sample high -> IDLE, key_level=0, pulse key_release; sample low -> HELD, hold counter unchanged, no event.
REQ-022 key_long SHALL pulse once, on the tick where the hold counter becomes LONG_TICKS.
REQ-023 With repeat_en=1, key_repeat SHALL pulse each time the hold counter reaches LONG_TICKS+REPEAT_TICKS; the counter then reloads LONG_TICKS, giving one repeat every REPEAT_TICKS ticks.
REQ-024 With repeat_en=0, key_repeat SHALL stay 0; key_long behaviour is unaffected.
REQ-025 All event outputs SHALL be registered and high for exactly one key_clk cycle, namely the cycle after the deciding tick.
REQ-026 Keys SHALL be fully independent; any number of keys may be pressed, held or released simultaneously, each producing its own pulses in the same cycle.
REQ-027 key_press and key_release for one key SHALL never be high in the same cycle; minimum press-to-release spacing is 2 ticks.
REQ-028 Tick counter and hold counters SHALL be sized by $clog2 of their maximums; no overflow or wrap is permitted in the hold counter.

Reset
REQ-029 On key_rst=1 at any time, SHALL asynchronously clear the tick counter, synchroniser flops to 1 (released), all FSMs to IDLE, all hold counters to 0 and all outputs to 0.
REQ-030 A reset asserted mid-hold SHALL NOT produce key_release; after reset deassertion a still-held key SHALL be re-detected as a new press after 2 ticks.

Verification (TICK_MAX=4, LONG_TICKS=5, REPEAT_TICKS=2, KEY_NUM=4)
REQ-031 Hold key_in=4'b1110 for 3 ticks, then 4'b1111 -> key_press[0] pulses once; key_release[0] pulses once 2 ticks after release; no key_long.
REQ-032 Drive key_in[1]=0 for 1 tick only -> no pulses on any output; key_level stays 0.
REQ-033 Hold key_in[2]=0 for 12 ticks with repeat_en=1 -> key_press, then key_long 5 ticks later, then key_repeat every 2 ticks; key_repeat count matches the number of whole 2-tick periods after key_long.
REQ-034 Press keys 0 and 3 on the same tick -> key_press=4'b1001 in one cycle; key_any=1 until both are released.
REQ-035 Assert key_rst while key 0 is held for 2 ticks -> all outputs 0 immediately and no key_release; after deassertion with key still low -> key_press[0] 2 ticks later.
REQ-036 Held key with a 1-tick high glitch -> REL_CHK returns to HELD; no release or press pulses and the long-press timing is unaffected.
